// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle field positions and slot operation codes
// for the pipeline stage register and its neighbours (decoder, hazard unit).
package pipe_pkg;

    localparam int unsigned DEF_DATA_W = 24;
    localparam int unsigned DEF_CTRL_W = 12;
    localparam int unsigned DEF_CNT_W  = 16;

    // Control-bundle bit positions; a bubble carries all of these as zero.
    localparam int unsigned CTRL_RD_LSB     = 0;
    localparam int unsigned CTRL_RD_MSB     = 2;
    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_READ   = 4;
    localparam int unsigned CTRL_MEM_WRITE  = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_JUMP       = 7;
    localparam int unsigned CTRL_BRANCH_EQ  = 8;
    localparam int unsigned CTRL_BRANCH_NE  = 9;
    localparam int unsigned CTRL_HALT       = 10;
    localparam int unsigned CTRL_FLAGS      = 11;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot (valid + ctrl + data) of the stage register.
// Clear wins over load; an empty slot always holds zero ctrl and data.
module pipe_slot #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/kill counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;
    logic              accept, drain, main_can_load;
    slot_op_e          main_op, skid_op;

    assign in_ready      = !skid_valid;
    assign accept        = in_valid && in_ready;
    assign drain         = main_valid && out_ready;
    assign main_can_load = !main_valid || drain;

    // Skid only fills while main is stuck, and in_ready is low whenever skid
    // is full, so "main loads from skid while accepting" cannot occur.
    always_comb begin
        main_op     = SLOT_HOLD;
        skid_op     = SLOT_HOLD;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
        if (flush) begin
            main_op = SLOT_CLEAR;
            skid_op = SLOT_CLEAR;
        end else if (main_can_load) begin
            if (skid_valid) begin
                main_op     = SLOT_LOAD;
                main_ctrl_d = skid_ctrl;
                main_data_d = skid_data;
                skid_op     = SLOT_CLEAR;
            end else if (accept) begin
                main_op = SLOT_LOAD;
            end else begin
                main_op = SLOT_CLEAR;
            end
        end else if (accept) begin
            skid_op = SLOT_LOAD;
        end
    end

    pipe_slot #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_main (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (main_op == SLOT_LOAD),
        .clear_i(main_op == SLOT_CLEAR),
        .ctrl_i (main_ctrl_d),
        .data_i (main_data_d),
        .valid_o(main_valid),
        .ctrl_o (main_ctrl),
        .data_o (main_data)
    );

    pipe_slot #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (skid_op == SLOT_LOAD),
        .clear_i(skid_op == SLOT_CLEAR),
        .ctrl_i (in_ctrl),
        .data_i (in_data),
        .valid_o(skid_valid),
        .ctrl_o (skid_ctrl),
        .data_o (skid_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (main_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (main_valid || skid_valid) && (kill_cnt_q != '1))
            kill_cnt_d = kill_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`else
    assign stall_cnt = '0;
    assign kill_cnt  = '0;
`endif

endmodule
